id_ex_pipe: RTL and testbench

Parametrised decode-to-execute pipeline stage. It is the elastic successor of the plain ID/EX register and carries the same decoded fields (rd address, RAM enable/direction, jump, flag type, operator, write-enable, two operands, RAM store data) between decode and execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so throughput is 1 beat/cycle with a registered in_ready.
- Adds synchronous flush for branch/jump kill.
- Squashes side-effect controls on bubbles.

---
 rtl/luu_pipe_pkg.sv | 70 +++++++
 rtl/pipe_skid_reg.sv | 96 +++++++++
 rtl/id_ex_pipe.sv | 111 +++++++++++
 tb/tb_id_ex_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/luu_pipe_pkg.sv
// Shared definitions for the LUU decode/execute pipeline slice.
//   - Default field widths of the ID/EX payload.
//   - Derived packed payload width and field offsets. The payload is packed
//     MSB..LSB as {rd_addr, ram_en, ram_rw, J, flag_t, oprt, wen, op1, op2, ram_ind}.
//   - Occupancy encoding used by the skid register.
// Offset helpers take the widths as arguments, so parametrised instances can
// derive their own layout from the same formulas as the defaults.
package luu_pipe_pkg;

  localparam int ID_EX_DATA_W = 32;
  localparam int ID_EX_REG_AW = 5;
  localparam int ID_EX_OPRT_W = 4;
  localparam int ID_EX_FLAG_W = 4;

  localparam int ID_EX_PAY_W = ID_EX_REG_AW + ID_EX_FLAG_W + ID_EX_OPRT_W + 4 + 3 * ID_EX_DATA_W;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int off_op2(input int data_w);
    return data_w;
  endfunction

  function automatic int off_op1(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_wen(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_oprt(input int data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int off_flag(input int data_w, input int oprt_w);
    return off_oprt(data_w) + oprt_w;
  endfunction

  function automatic int off_j(input int data_w, input int oprt_w, input int flag_w);
    return off_flag(data_w, oprt_w) + flag_w;
  endfunction

  function automatic int off_ram_rw(input int data_w, input int oprt_w, input int flag_w);
    return off_j(data_w, oprt_w, flag_w) + 1;
  endfunction

  function automatic int off_ram_en(input int data_w, input int oprt_w, input int flag_w);
    return off_j(data_w, oprt_w, flag_w) + 2;
  endfunction

  function automatic int off_rd(input int data_w, input int oprt_w, input int flag_w);
    return off_j(data_w, oprt_w, flag_w) + 3;
  endfunction

  localparam int ID_EX_OFF_RAM_IND = 0;
  localparam int ID_EX_OFF_OP2     = off_op2(ID_EX_DATA_W);
  localparam int ID_EX_OFF_OP1     = off_op1(ID_EX_DATA_W);
  localparam int ID_EX_OFF_WEN     = off_wen(ID_EX_DATA_W);
  localparam int ID_EX_OFF_OPRT    = off_oprt(ID_EX_DATA_W);
  localparam int ID_EX_OFF_FLAG    = off_flag(ID_EX_DATA_W, ID_EX_OPRT_W);
  localparam int ID_EX_OFF_J       = off_j(ID_EX_DATA_W, ID_EX_OPRT_W, ID_EX_FLAG_W);
  localparam int ID_EX_OFF_RAM_RW  = off_ram_rw(ID_EX_DATA_W, ID_EX_OPRT_W, ID_EX_FLAG_W);
  localparam int ID_EX_OFF_RAM_EN  = off_ram_en(ID_EX_DATA_W, ID_EX_OPRT_W, ID_EX_FLAG_W);
  localparam int ID_EX_OFF_RD      = off_rd(ID_EX_DATA_W, ID_EX_OPRT_W, ID_EX_FLAG_W);

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic W-bit valid/ready pipeline register with a one-entry skid buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop main + skid contents and any incoming beat
//   in_valid/in_ready   upstream handshake; in_ready is a register (= no skid held)
//   in_data             upstream payload
//   squash_mask         payload bits forced to 0 whenever main goes empty
//   out_valid/out_ready downstream handshake
//   out_data            main register contents
module pipe_skid_reg
  import luu_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] squash_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         r_state, w_state_nxt;
  logic [W-1:0] r_main, w_main_nxt;
  logic [W-1:0] r_skid, w_skid_nxt;
  logic         r_in_ready;
  logic         w_in_fire;
  logic         w_out_fire;

  assign out_valid  = (r_state != OCC_EMPTY);
  assign out_data   = r_main;
  assign in_ready   = r_in_ready;
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Killed beats leave side-effect controls cleared in the bubble.
      w_state_nxt = OCC_EMPTY;
      w_main_nxt  = r_main & ~squash_mask;
    end else begin
      unique case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && out_ready) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = OCC_FULL;
          end else if (w_out_fire) begin
            w_main_nxt  = r_main & ~squash_mask;
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = OCC_ONE;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_main     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      // Registered ready: accept next cycle unless the skid will be holding a beat.
      r_in_ready <= (w_state_nxt != OCC_FULL);
    end
  end

  // Skid contents are only meaningful while FULL, so they need no reset.
  always_ff @(posedge clk) begin
    r_skid <= w_skid_nxt;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// Elastic decode-to-execute pipeline stage.
// Carries decoded controls (rd_addr, ram_en, ram_rw, J, flag_t, oprt, wen) and
// data (op1, op2, ram_ind) through a valid/ready skid register with flush.
// On any bubble wen/ram_en/ram_rw/J are cleared; other fields hold.
// Ports:
//   clk, rst, flush                         clock, sync active-high reset, kill
//   in_valid/in_ready, *_i                  decode side
//   out_valid/out_ready, *_o                execute side
//   stall_cnt_o                             backpressure cycle count, saturating
// Optional: define ID_EX_STALL_CNT_EN to add stall_cnt_o (CNT_W bits).
module id_ex_pipe
  import luu_pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int REG_AW = ID_EX_REG_AW,
  parameter int OPRT_W = ID_EX_OPRT_W,
  parameter int FLAG_W = ID_EX_FLAG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              ram_en_i,
  input  logic              ram_rw_i,
  input  logic              J_i,
  input  logic [FLAG_W-1:0] flag_t_i,
  input  logic [OPRT_W-1:0] oprt_i,
  input  logic              wen_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [DATA_W-1:0] ram_ind_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              ram_en_o,
  output logic              ram_rw_o,
  output logic              J_o,
  output logic [FLAG_W-1:0] flag_t_o,
  output logic [OPRT_W-1:0] oprt_o,
  output logic              wen_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output logic [DATA_W-1:0] ram_ind_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam int PAY_W      = REG_AW + FLAG_W + OPRT_W + 4 + 3 * DATA_W;
  localparam int OFF_WEN    = off_wen(DATA_W);
  localparam int OFF_J      = off_j(DATA_W, OPRT_W, FLAG_W);
  localparam int OFF_RAM_RW = off_ram_rw(DATA_W, OPRT_W, FLAG_W);
  localparam int OFF_RAM_EN = off_ram_en(DATA_W, OPRT_W, FLAG_W);

  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_out_pay;
  logic [PAY_W-1:0] w_squash;

  assign w_in_pay = {rd_addr_i, ram_en_i, ram_rw_i, J_i, flag_t_i, oprt_i, wen_i,
                     op1_i, op2_i, ram_ind_i};

  assign {rd_addr_o, ram_en_o, ram_rw_o, J_o, flag_t_o, oprt_o, wen_o,
          op1_o, op2_o, ram_ind_o} = w_out_pay;

  // Only controls with side effects in execute are squashed on bubbles.
  always_comb begin
    w_squash             = '0;
    w_squash[OFF_WEN]    = 1'b1;
    w_squash[OFF_J]      = 1'b1;
    w_squash[OFF_RAM_RW] = 1'b1;
    w_squash[OFF_RAM_EN] = 1'b1;
  end

  pipe_skid_reg #(
    .W(PAY_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (w_in_pay),
    .squash_mask(w_squash),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (w_out_pay)
  );

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where execute refuses a valid beat; flush keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rd_addr_i = '0;
  logic        ram_en_i = 1'b0;
  logic        ram_rw_i = 1'b0;
  logic        J_i = 1'b0;
  logic [3:0]  flag_t_i = '0;
  logic [3:0]  oprt_i = '0;
  logic        wen_i = 1'b0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [31:0] ram_ind_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rd_addr_o;
  logic        ram_en_o;
  logic        ram_rw_o;
  logic        J_o;
  logic [3:0]  flag_t_o;
  logic [3:0]  oprt_o;
  logic        wen_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] ram_ind_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [3:0]  stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(
    .DATA_W(32), .REG_AW(5), .OPRT_W(4), .FLAG_W(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr_i(rd_addr_i), .ram_en_i(ram_en_i), .ram_rw_i(ram_rw_i), .J_i(J_i),
    .flag_t_i(flag_t_i), .oprt_i(oprt_i), .wen_i(wen_i),
    .op1_i(op1_i), .op2_i(op2_i), .ram_ind_i(ram_ind_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr_o(rd_addr_o), .ram_en_o(ram_en_o), .ram_rw_o(ram_rw_o), .J_o(J_o),
    .flag_t_o(flag_t_o), .oprt_o(oprt_o), .wen_o(wen_o),
    .op1_o(op1_o), .op2_o(op2_o), .ram_ind_o(ram_ind_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; rd_addr_i = 0; ram_en_i = 0; ram_rw_i = 0; J_i = 0;
    flag_t_i = 0; oprt_i = 0; wen_i = 0; op1_i = 0; op2_i = 0; ram_ind_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; op1_i = 32'hDEAD; wen_i = 1; rd_addr_i = 5'd7; out_ready = 0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL reset_op1 got %h want 0", op1_o); end
    n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", wen_o); end
    n_checks++; if (rd_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd_addr_o); end
    clear_inputs();
    rst = 0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; op1_i = 32'(i);
      tick();
      n_checks++; if (op1_o !== 32'(i)) begin n_fail++; $display("FAIL stream_op1_%0d got %h want %h", i, op1_o, i); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid_%0d got %b want 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready_%0d got %b want 1", i, in_ready); end
    end
    clear_inputs();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 0;
    in_valid = 1; rd_addr_i = 5'd5; wen_i = 1; op1_i = 32'hAAAA;
    tick();
    n_checks++; if (rd_addr_o !== 5'd5) begin n_fail++; $display("FAIL skid_A_rd got %h want 5", rd_addr_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_one_ready got %b want 1", in_ready); end
    rd_addr_i = 5'd6; wen_i = 0; op1_i = 32'hBBBB;
    tick();
    clear_inputs();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready got %b want 0", in_ready); end
    n_checks++; if (rd_addr_o !== 5'd5) begin n_fail++; $display("FAIL skid_A_hold_rd got %h want 5", rd_addr_o); end
    tick();
    n_checks++; if ({rd_addr_o, wen_o, op1_o} !== {5'd5, 1'b1, 32'hAAAA}) begin n_fail++;
      $display("FAIL skid_A_stall got %h/%b/%h want 5/1/aaaa", rd_addr_o, wen_o, op1_o); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_stall_valid got %b want 1", out_valid); end
    out_ready = 1;
    tick();
    n_checks++; if ({rd_addr_o, wen_o, op1_o} !== {5'd6, 1'b0, 32'hBBBB}) begin n_fail++;
      $display("FAIL skid_B got %h/%b/%h want 6/0/bbbb", rd_addr_o, wen_o, op1_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_B_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_B_valid got %b want 1", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    // Flush while FULL.
    out_ready = 0;
    in_valid = 1; rd_addr_i = 5'd3; wen_i = 1; ram_en_i = 1; J_i = 1;
    tick();
    rd_addr_i = 5'd4;
    tick();
    n_checks++; if ({in_ready, wen_o} !== 2'b01) begin n_fail++; $display("FAIL flush_pre_full got %b%b want 01", in_ready, wen_o); end
    flush = 1; rd_addr_i = 5'd9;
    tick();
    flush = 0; clear_inputs();
    n_checks++; if ({out_valid, wen_o, ram_en_o, J_o} !== 4'b0000) begin n_fail++;
      $display("FAIL flush_full_bubble got %b%b%b%b want 0000", out_valid, wen_o, ram_en_o, J_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready got %b want 1", in_ready); end
    n_checks++; if (rd_addr_o !== 5'd3) begin n_fail++; $display("FAIL flush_full_rd got %h want 3", rd_addr_o); end
    out_ready = 1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_skid_beat got %b want 0", out_valid); end
    // Flush while ONE with an accepted incoming beat that must be discarded.
    out_ready = 0;
    in_valid = 1; rd_addr_i = 5'd10; wen_i = 1;
    tick();
    flush = 1; rd_addr_i = 5'd9;
    tick();
    flush = 0; clear_inputs();
    n_checks++; if ({out_valid, wen_o} !== 2'b00) begin n_fail++; $display("FAIL flush_one_bubble got %b%b want 00", out_valid, wen_o); end
    n_checks++; if (rd_addr_o !== 5'd10) begin n_fail++; $display("FAIL flush_one_rd got %h want 0a", rd_addr_o); end
    out_ready = 1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got %b want 0", out_valid); end
  endtask

  task automatic test_drain_squash();
    out_ready = 1;
    in_valid = 1; rd_addr_i = 5'd2; ram_en_i = 1; ram_rw_i = 1; J_i = 1; wen_i = 1;
    flag_t_i = 4'hA; oprt_i = 4'h5; op1_i = 32'h1234_5678; op2_i = 32'h55; ram_ind_i = 32'hCAFE_F00D;
    tick();
    clear_inputs();
    n_checks++; if ({rd_addr_o, ram_en_o, ram_rw_o, J_o, flag_t_o, oprt_o, wen_o} !== {5'd2, 3'b111, 4'hA, 4'h5, 1'b1}) begin n_fail++;
      $display("FAIL drain_ctrl got %h %b%b%b %h %h %b want 02 111 a 5 1", rd_addr_o, ram_en_o, ram_rw_o, J_o, flag_t_o, oprt_o, wen_o); end
    n_checks++; if ({op1_o, op2_o, ram_ind_o} !== {32'h1234_5678, 32'h55, 32'hCAFE_F00D}) begin n_fail++;
      $display("FAIL drain_data got %h %h %h want 12345678 00000055 cafef00d", op1_o, op2_o, ram_ind_o); end
    tick();
    n_checks++; if ({out_valid, ram_en_o, ram_rw_o, J_o, wen_o} !== 5'b00000) begin n_fail++;
      $display("FAIL drain_squash got %b%b%b%b%b want 00000", out_valid, ram_en_o, ram_rw_o, J_o, wen_o); end
    n_checks++; if ({op2_o, rd_addr_o, flag_t_o, oprt_o} !== {32'h55, 5'd2, 4'hA, 4'h5}) begin n_fail++;
      $display("FAIL drain_hold got %h %h %h %h want 55 2 a 5", op2_o, rd_addr_o, flag_t_o, oprt_o); end
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_counter();
    out_ready = 0;
    in_valid = 1; op1_i = 32'h77;
    tick();
    clear_inputs();
    n_checks++; if (stall_cnt_o !== 4'h0) begin n_fail++; $display("FAIL cnt_start got %h want 0", stall_cnt_o); end
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (stall_cnt_o !== 4'hF) begin n_fail++; $display("FAIL cnt_sat got %h want f", stall_cnt_o); end
    flush = 1;
    tick();
    flush = 0;
    n_checks++; if (stall_cnt_o !== 4'hF) begin n_fail++; $display("FAIL cnt_flush got %h want f", stall_cnt_o); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (stall_cnt_o !== 4'h0) begin n_fail++; $display("FAIL cnt_rst got %h want 0", stall_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_drain_squash();
`ifdef ID_EX_STALL_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
